// File: rtl/imem_loader.sv
// Host-side loader: parses a framed byte stream, writes the payload into instruction memory
// from address 0 upward, verifies an 8-bit checksum and holds the CPU in reset until it passes.
module imem_loader #(
    parameter int unsigned         AddrW    = 8,
    parameter int unsigned         DataW    = 8,
    parameter logic [DataW-1:0]    SyncByte = 8'hA5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [DataW-1:0] host_data_i,
    input  logic             host_valid_i,
    output logic             host_ready_o,
    input  logic             reload_i,
    output logic [AddrW-1:0] mem_addr_o,
    output logic [DataW-1:0] mem_wdata_o,
    output logic             mem_we_o,
    output logic             cpu_reset_o,
    output logic             load_done_o,
    output logic             load_err_o
);

    typedef enum logic [2:0] {
        StIdle, StSync, StLen, StData, StCsum, StRun, StErr
    } state_e;

    state_e           state_q, state_d;
    logic [AddrW-1:0] len_q, len_d;
    logic [AddrW-1:0] cnt_q, cnt_d;
    logic [DataW-1:0] sum_q, sum_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic [DataW-1:0] wdata_q, wdata_d;
    logic             we_q, we_d;
    logic             host_ready;
    logic             xfer;
    logic [DataW-1:0] csum_chk;

    assign host_ready = (state_q == StSync) || (state_q == StLen) ||
                        (state_q == StData) || (state_q == StCsum);
    assign xfer       = host_valid_i && host_ready;
    assign csum_chk   = sum_q + host_data_i;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        // Reload has priority over any handshake in the same cycle.
        if (reload_i && (state_q != StIdle)) begin
            state_d = StSync;
            cnt_d   = '0;
            sum_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StSync;
                StSync: begin
                    if (xfer && (host_data_i == SyncByte)) state_d = StLen;
                end
                StLen: begin
                    if (xfer) begin
                        len_d   = AddrW'(host_data_i);
                        cnt_d   = '0;
                        sum_d   = '0;
                        state_d = (AddrW'(host_data_i) == '0) ? StErr : StData;
                    end
                end
                StData: begin
                    if (xfer) begin
                        addr_d  = cnt_q;
                        wdata_d = host_data_i;
                        we_d    = 1'b1;
                        sum_d   = sum_q + host_data_i;
                        cnt_d   = cnt_q + AddrW'(1);
                        if (cnt_q == len_q - AddrW'(1)) state_d = StCsum;
                    end
                end
                StCsum: begin
                    if (xfer) state_d = (csum_chk == '0) ? StRun : StErr;
                end
                StRun, StErr: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            len_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    assign host_ready_o = host_ready;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_we_o     = we_q;
    assign cpu_reset_o  = (state_q != StRun);
    assign load_done_o  = (state_q == StRun);
    assign load_err_o   = (state_q == StErr);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frames plus randomized frames checked against a stream-parsing
// reference model and a shadow of instruction memory.
module tb_imem_loader;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] host_data;
    logic       host_valid;
    logic       host_ready;
    logic       reload;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       cpu_reset;
    logic       load_done;
    logic       load_err;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .host_data_i  (host_data),
        .host_valid_i (host_valid),
        .host_ready_o (host_ready),
        .reload_i     (reload),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_we_o     (mem_we),
        .cpu_reset_o  (cpu_reset),
        .load_done_o  (load_done),
        .load_err_o   (load_err)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    wr_t        act_w[$];
    wr_t        exp_w[$];
    logic [7:0] stim[$];
    logic [7:0] mem_model[256];
    int         exp_out;  // 0 = frame incomplete, 1 = accepted, 2 = rejected

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Shadow memory and write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            act_w.push_back('{a: mem_addr, d: mem_wdata});
            mem_model[mem_addr] = mem_wdata;
        end
    end

    // Reference: parse the byte stream as a frame and predict writes and the final verdict.
    task automatic model();
        int i = 0;
        int len;
        int sum = 0;
        exp_w.delete();
        exp_out = 0;
        while (i < stim.size() && stim[i] != 8'hA5) i++;
        if (i >= stim.size()) return;
        i++;
        if (i >= stim.size()) return;
        len = int'(stim[i]);
        i++;
        if (len == 0) begin
            exp_out = 2;
            return;
        end
        for (int k = 0; k < len; k++) begin
            if (i >= stim.size()) return;
            exp_w.push_back('{a: 8'(k), d: stim[i]});
            sum += int'(stim[i]);
            i++;
        end
        if (i >= stim.size()) return;
        exp_out = ((sum + int'(stim[i])) % 256 == 0) ? 1 : 2;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget = 0;
        repeat (gap) begin
            @(negedge clk);
            host_valid = 1'b0;
        end
        @(negedge clk);
        host_valid = 1'b1;
        host_data  = b;
        while (!host_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!host_ready) begin
            check_eq("hs_timeout", 32'(host_ready), 32'd1);
            host_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic send_stream(input int gap);
        for (int i = 0; i < stim.size(); i++)
            send_byte(stim[i], (gap < 0) ? int'($urandom_range(0, 3)) : gap);
        @(negedge clk);
        host_valid = 1'b0;
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        #1;
        check_eq("reload_ready", 32'(host_ready), 32'd1);
        check_eq("reload_cpu_rst", 32'(cpu_reset), 32'd1);
        check_eq("reload_flags", {load_done, load_err}, 32'd0);
    endtask

    task automatic run_frame(input string tag, input int gap);
        model();
        act_w.delete();
        send_stream(gap);
        repeat (2) @(negedge clk);
        #1;
        check_eq({tag, "_nwr"}, act_w.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < act_w.size(); i++)
            check_eq({tag, "_wr"}, act_w[i], exp_w[i]);
        for (int i = 0; i < exp_w.size(); i++)
            check_eq({tag, "_mem"}, mem_model[exp_w[i].a], exp_w[i].d);
        check_eq({tag, "_done"}, 32'(load_done), 32'(exp_out == 1));
        check_eq({tag, "_err"}, 32'(load_err), 32'(exp_out == 2));
        check_eq({tag, "_cpu_rst"}, 32'(cpu_reset), 32'(exp_out != 1));
        check_eq({tag, "_ready"}, 32'(host_ready), 32'(exp_out == 0));
        pulse_reload();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        host_valid = 1'b0;
        host_data  = 8'h00;
        reload     = 1'b0;
        for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;

        // Reset values, then SYNC one edge after release.
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(host_ready), 32'd0);
        check_eq("rst_cpu_rst", 32'(cpu_reset), 32'd1);
        check_eq("rst_flags", {load_done, load_err}, 32'd0);
        check_eq("rst_we", 32'(mem_we), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_wdata", 32'(mem_wdata), 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("rel_ready0", 32'(host_ready), 32'd0);
        @(negedge clk);
        check_eq("rel_ready1", 32'(host_ready), 32'd1);
        check_eq("rel_cpu_rst", 32'(cpu_reset), 32'd1);

        stim = '{8'hA5, 8'h03, 8'h12, 8'h34, 8'h56, 8'h64};
        run_frame("good", 0);
        stim = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
        run_frame("badcs", 0);
        stim = '{8'h00, 8'hFF, 8'hA5, 8'h00};
        run_frame("zlen", 0);
        stim = '{8'hA5, 8'h03, 8'h12, 8'h34, 8'h56, 8'h64};
        run_frame("gaps", 2);

        // Abort via reload after two payload bytes, then a full frame.
        stim = '{8'hA5, 8'h03, 8'h12, 8'h34};
        act_w.delete();
        send_stream(0);
        pulse_reload();
        check_eq("abort_nwr", act_w.size(), 32'd2);
        stim = '{8'hA5, 8'h03, 8'h12, 8'h34, 8'h56, 8'h64};
        run_frame("reload", 0);
        check_eq("reload_m0", mem_model[0], 32'h12);
        check_eq("reload_m1", mem_model[1], 32'h34);
        check_eq("reload_m2", mem_model[2], 32'h56);

        // Asynchronous reset while a payload write is on the bus.
        stim = '{8'hA5, 8'h03, 8'h12};
        send_stream(0);
        check_eq("pre_rst_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_we", 32'(mem_we), 32'd0);
        check_eq("mid_rst_ready", 32'(host_ready), 32'd0);
        check_eq("mid_rst_cpu", 32'(cpu_reset), 32'd1);
        check_eq("mid_rst_addr", {mem_addr, mem_wdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", 32'(host_ready), 32'd1);
        stim = '{8'hA5, 8'h03, 8'h12, 8'h34, 8'h56, 8'h64};
        run_frame("after_rst", 0);

        // Randomized frames: optional noise, random length (sometimes zero), good or bad checksum.
        for (int t = 0; t < 25; t++) begin
            int         len;
            int         sum = 0;
            logic [7:0] b;
            stim.delete();
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h00;
                stim.push_back(b);
            end
            stim.push_back(8'hA5);
            len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
            stim.push_back(8'(len));
            if (len != 0) begin
                for (int k = 0; k < len; k++) begin
                    b = 8'($urandom_range(0, 255));
                    stim.push_back(b);
                    sum += int'(b);
                end
                if ($urandom_range(0, 2) != 0)
                    stim.push_back(8'((256 - sum % 256) % 256));
                else
                    stim.push_back(8'((256 - sum % 256 + int'($urandom_range(1, 255))) % 256));
            end
            run_frame("rnd", -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Host-side writer that fills the CPU's 256-byte instruction memory before execution. It takes a framed byte stream over a valid/ready handshake, writes the payload into instruction memory from address 0x00 upward, and verifies an 8-bit checksum. It holds the CPU's PC in reset until a frame loads cleanly. It is the writing end of the instruction-fetch path: the CPU only reads instruction memory, and this block is the only agent that writes it.

## Interface
- ADDR_W, 8, instruction-memory address width; the frame length field is also ADDR_W bits.
- DATA_W, 8, instruction/byte width.
- SYNC_BYTE, 8'hA5, frame start marker.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- host_data  in  DATA_W  byte from the host.
- host_valid  in  1  host_data is valid.
- host_ready  out  1  loader accepts a byte this cycle; transfer = host_valid & host_ready.
- reload  in  1  single-cycle request to abort or restart and return to SYNC.
- mem_addr  out  ADDR_W  instruction-memory write address.
- mem_wdata  out  DATA_W  instruction-memory write data.
- mem_we  out  1  write strobe, one cycle per payload byte.
- cpu_reset  out  1  active-high; drives the PC reset. 1 = CPU held.
- load_done  out  1  frame accepted; CPU running.
- load_err  out  1  frame rejected.

## Operation
- Frame format: SYNC_BYTE, then length L (1..255), then L payload bytes, then checksum C.
  - The frame is valid when (sum of payload bytes + C) mod 256 == 0.
- States: IDLE, SYNC, LEN, DATA, CSUM, RUN, ERR. The state register is reset to IDLE.
- IDLE -> SYNC unconditionally on the next edge.
- SYNC: an accepted byte equal to SYNC_BYTE -> LEN. Any other accepted byte is discarded and the state stays SYNC.
- LEN: the accepted byte is stored as L, and cnt and sum are cleared.
  - L == 0 -> ERR.
  - Otherwise -> DATA.
- DATA: on each accepted byte b:
  - register mem_addr <= cnt, mem_wdata <= b, mem_we <= 1;
  - sum <= sum + b (8-bit, wraps mod 256);
  - cnt <= cnt + 1.
  - When the accepted byte is the L-th byte (cnt == L-1), go -> CSUM.
- CSUM: on an accepted byte, (sum + byte) mod 256 == 0 -> RUN; otherwise -> ERR.
- RUN: cpu_reset = 0, load_done = 1. Stays in RUN until reload or reset.
- ERR: cpu_reset = 1, load_err = 1. Stays in ERR until reload or reset.
- reload, sampled high in any state other than IDLE:
  - next state is SYNC;
  - cnt and sum are cleared;
  - cpu_reset, load_done and load_err take their SYNC values;
  - no byte is accepted in that cycle, because reload overrides the transfer.
- Memory written before an abort is not rolled back. A successful later frame overwrites only addresses 0..L-1.
- host_ready = 1 in SYNC, LEN, DATA and CSUM; 0 in IDLE, RUN and ERR. It is decoded from the registered state (Moore).
- cpu_reset = 0 only in RUN. load_done = 1 only in RUN. load_err = 1 only in ERR.

## Timing
- Reset values of outputs:
  - host_ready = 0, cpu_reset = 1, load_done = 0, load_err = 0;
  - mem_we = 0, mem_addr = 0x00, mem_wdata = 0x00.
- host_ready rises one edge after reset is released (IDLE -> SYNC).
- Write latency: a payload byte accepted at edge N produces mem_we = 1, with its address and data, during cycle N..N+1. The memory captures it at edge N+1.
- mem_we is high for exactly one cycle per accepted payload byte. mem_addr and mem_wdata hold their last values while mem_we = 0.
- Back-to-back bytes are accepted at one per cycle; host_ready never stalls inside a frame.
- host_valid gaps pause the FSM with no change to state, cnt or sum.
- The last payload byte's write and the CSUM-state entry happen on the same edge, so the write has committed before the checksum byte can be accepted.
- Checksum byte accepted at edge N: the state changes at edge N, and cpu_reset falls (or load_err rises) in the cycle that follows. The CPU's first fetch is at edge N+1.
- Asynchronous reset mid-frame: outputs go to their reset values immediately, with no partial mem_we pulse after the assertion.

## Test plan
- Reset release: hold reset = 0 for 3 cycles. Expect the reset values above. Then host_ready = 1 on the first edge after release, and cpu_reset stays 1.
- Good frame: send A5, 03, 12, 34, 56, 64 back-to-back.
  - Expect mem_we pulses writing 12 @00, 34 @01 and 56 @02.
  - Then load_done = 1, cpu_reset = 0 and host_ready = 0.
- Bad checksum: send A5, 02, 10, 20, 00.
  - Expect writes 10 @00 and 20 @01.
  - Then load_err = 1, cpu_reset = 1 and host_ready = 0.
- Zero length plus noise: send 00, FF, A5, 00.
  - Expect FF and the first 00 discarded, no mem_we, and ERR with load_err = 1.
- Handshake gaps: send the good frame with host_valid dropped for 2 cycles between every byte.
  - Expect the same three writes with identical addr/data.
  - Expect no extra mem_we and load_done = 1.
- Abort paths:
  - Pulse reload after the 2nd payload byte, then send a full good frame. Expect a clean reload, load_done = 1, and contents 12/34/56.
  - Separately, assert reset mid-DATA. Expect immediate reset values, and the FSM back in SYNC one edge after release.
